// File: rtl/arb_grant_lock_if.sv
// ----------------------------------------------------------------------------
// arb_grant_lock_if
//   Bundles the request/grant signals between the upstream fixed-priority
//   arbiter, the requesters and the arb_grant_lock stage.
//
//   Parameters:
//     N          number of requesters
//
//   Signals:
//     req        raw (unmasked) requests from the requesters
//     grt_in     one-hot combinational grant from the upstream arbiter
//     gnt        registered one-hot grant to the current owner
//     gnt_vld    high while gnt is nonzero
//     gnt_id     binary index of the owner, 0 when no grant
//     req_mask   per-requester mask fed back to the arbiter input
//     timeout    single-cycle pulse when a grant ends by hold timeout
//     onehot_err sticky multi-hot grant flag (only with ARB_LOCK_ONEHOT_CHK_EN)
//
//   Modports:
//     slave      lock stage side (drives the grant outputs)
//     master     environment side (drives req and grt_in)
//
//   Optional feature macro: ARB_LOCK_ONEHOT_CHK_EN
// ----------------------------------------------------------------------------
interface arb_grant_lock_if #(
    parameter int N = 5
);
    logic [N-1:0] req;
    logic [N-1:0] grt_in;
    logic [N-1:0] gnt;
    logic         gnt_vld;
    logic [2:0]   gnt_id;
    logic [N-1:0] req_mask;
    logic         timeout;
`ifdef ARB_LOCK_ONEHOT_CHK_EN
    logic         onehot_err;

    modport slave (
        input  req,
        input  grt_in,
        output gnt,
        output gnt_vld,
        output gnt_id,
        output req_mask,
        output timeout,
        output onehot_err
    );

    modport master (
        output req,
        output grt_in,
        input  gnt,
        input  gnt_vld,
        input  gnt_id,
        input  req_mask,
        input  timeout,
        input  onehot_err
    );
`else
    modport slave (
        input  req,
        input  grt_in,
        output gnt,
        output gnt_vld,
        output gnt_id,
        output req_mask,
        output timeout
    );

    modport master (
        output req,
        output grt_in,
        input  gnt,
        input  gnt_vld,
        input  gnt_id,
        input  req_mask,
        input  timeout
    );
`endif
endinterface

// File: rtl/arb_grant_lock.sv
// ----------------------------------------------------------------------------
// arb_grant_lock
//   Grant-lock stage behind an N-requester fixed-priority arbiter. It
//   registers the arbiter's one-hot grant, holds it for the owner while the
//   owner keeps requesting (bounded by MAX_HOLD cycles), inserts a one-cycle
//   turnaround gap after every grant, and masks a timed-out owner so it
//   cannot immediately re-win. The arbiter is expected to see req & ~req_mask.
//
//   Parameters:
//     N         number of requesters (gnt_id is 3 bits, so N <= 8)
//     MAX_HOLD  maximum consecutive grant cycles, legal range 2..256
//     CNT_W     hold counter width, 2^CNT_W >= MAX_HOLD
//
//   Ports:
//     clk       system clock, rising edge
//     rst       synchronous active-high reset
//     bus       arb_grant_lock_if.slave: req/grt_in in, gnt/gnt_vld/gnt_id/
//               req_mask/timeout (and onehot_err) out, all registered
//
//   Optional feature macro: ARB_LOCK_ONEHOT_CHK_EN
//     defined   a multi-hot masked grant in IDLE is refused and raises the
//               sticky onehot_err output
//     undefined a multi-hot masked grant selects its lowest set index
// ----------------------------------------------------------------------------
module arb_grant_lock #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input logic             clk,
    input logic             rst,
    arb_grant_lock_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // Lowest set index of a vector; matches the upstream priority order.
    function automatic logic [2:0] lowest_index(input logic [N-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Binary index to one-hot, written as a compare loop so that indices
    // beyond N simply produce zero.
    function automatic logic [N-1:0] to_onehot(input logic [2:0] idx);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i] = (idx == 3'(i));
        end
        return v;
    endfunction

`ifdef ARB_LOCK_ONEHOT_CHK_EN
    // True when more than one bit is set.
    function automatic logic is_multi_hot(input logic [N-1:0] v);
        return ((v & (v - {{(N-1){1'b0}}, 1'b1})) != {N{1'b0}});
    endfunction
`endif

    state_t           state_q,    state_d;
    logic [2:0]       owner_q,    owner_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     gnt_q,      gnt_d;
    logic             gnt_vld_q,  gnt_vld_d;
    logic [2:0]       gnt_id_q,   gnt_id_d;
    logic [N-1:0]     req_mask_q, req_mask_d;
    logic             timeout_q,  timeout_d;
`ifdef ARB_LOCK_ONEHOT_CHK_EN
    logic             onehot_err_q, onehot_err_d;
`endif

    logic [N-1:0]     g_s;
    logic [2:0]       g_idx_s;
    logic             req_owner_s;

    // Masked upstream grant, its priority index and the owner's live request.
    always_comb begin
        g_s         = bus.grt_in & ~req_mask_q;
        g_idx_s     = lowest_index(g_s);
        req_owner_s = |(bus.req & to_onehot(owner_q));
    end

    // Next-state and registered-output computation for the lock FSM.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = {N{1'b0}};
        gnt_vld_d  = 1'b0;
        gnt_id_d   = 3'd0;
        timeout_d  = 1'b0;
        // A low request always clears its mask bit; a set below only ever
        // targets a requester that is still requesting, so they never clash.
        req_mask_d = req_mask_q & bus.req;
`ifdef ARB_LOCK_ONEHOT_CHK_EN
        onehot_err_d = onehot_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (g_s != {N{1'b0}}) begin
`ifdef ARB_LOCK_ONEHOT_CHK_EN
                    if (is_multi_hot(g_s)) begin
                        // Refuse an ambiguous grant and stay idle.
                        onehot_err_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        owner_d    = g_idx_s;
                        hold_cnt_d = {CNT_W{1'b0}};
                        state_d    = ST_BUSY;
                        gnt_d      = to_onehot(g_idx_s);
                        gnt_vld_d  = 1'b1;
                        gnt_id_d   = g_idx_s;
                    end
`else
                    owner_d    = g_idx_s;
                    hold_cnt_d = {CNT_W{1'b0}};
                    state_d    = ST_BUSY;
                    gnt_d      = to_onehot(g_idx_s);
                    gnt_vld_d  = 1'b1;
                    gnt_id_d   = g_idx_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // grt_in is deliberately not looked at: the owner cannot be
                // preempted. Release wins over timeout on the same cycle.
                if (!req_owner_s) begin
                    state_d = ST_GAP;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_GAP;
                    timeout_d  = 1'b1;
                    req_mask_d = req_mask_d | to_onehot(owner_q);
                end else begin
                    state_d    = ST_BUSY;
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    gnt_d      = to_onehot(owner_q);
                    gnt_vld_d  = 1'b1;
                    gnt_id_d   = owner_q;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                owner_d    = 3'd0;
                hold_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 3'd0;
            hold_cnt_q <= {CNT_W{1'b0}};
            gnt_q      <= {N{1'b0}};
            gnt_vld_q  <= 1'b0;
            gnt_id_q   <= 3'd0;
            req_mask_q <= {N{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_id_q   <= gnt_id_d;
            req_mask_q <= req_mask_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef ARB_LOCK_ONEHOT_CHK_EN
    // Sticky multi-hot error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_err_q <= 1'b0;
        end else begin
            onehot_err_q <= onehot_err_d;
        end
    end

    assign bus.onehot_err = onehot_err_q;
`endif

    assign bus.gnt      = gnt_q;
    assign bus.gnt_vld  = gnt_vld_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.req_mask = req_mask_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: doc/arb_grant_lock.md
Name: arb_grant_lock

Overview:
- Downstream stage of the 5-requester fixed-priority arbiter.
- Registers the arbiter's one-hot combinational grant and holds it for the owner while that requester keeps its request high. The hold is bounded by MAX_HOLD cycles.
- Inserts a one-cycle bus-turnaround gap after every grant.
- Drives a request mask back upstream so a timed-out owner cannot immediately re-win. The upstream arbiter is fed req & ~req_mask.

Parameters:
- N, 5: number of requesters; matches arbiter width.
- MAX_HOLD, 16: maximum consecutive cycles a grant is held; legal range 2..256.
- CNT_W, 8: hold counter width; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  N  raw (unmasked) requests from requesters.
- grt_in  input  N  one-hot grant from the upstream priority arbiter (combinational on the masked requests).
- gnt  output  N  registered one-hot grant to the granted requester.
- gnt_vld  output  1  high while gnt is nonzero.
- gnt_id  output  3  binary index of the owner; 0 when gnt_vld=0.
- req_mask  output  N  per-requester mask fed back to the arbiter input.
- timeout  output  1  single-cycle pulse when a grant is terminated by MAX_HOLD.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- Reset, taken at the next rising edge, including mid-grant:
  - state=IDLE, gnt=0, gnt_vld=0, gnt_id=0, req_mask=0, timeout=0, hold_cnt=0, owner=0.
  - A mid-grant reset drops gnt at that edge with no gap cycle and no timeout.
- States: IDLE, BUSY, GAP.
- IDLE:
  - Let g = grt_in & ~req_mask.
  - If g != 0: latch owner=index(g), hold_cnt=0, next=BUSY.
  - Else stay in IDLE.
  - Latency: grt_in sampled at edge t gives gnt valid in cycle t+1.
- BUSY:
  - gnt=onehot(owner), gnt_vld=1, gnt_id=owner.
  - If req[owner]==0: next=GAP (normal release); gnt drops at the next edge.
  - Else if hold_cnt==MAX_HOLD-1: next=GAP, set req_mask[owner]=1, timeout=1 during the GAP cycle. The grant therefore lasts exactly MAX_HOLD cycles.
  - Else hold_cnt++.
  - Release takes priority over timeout when both conditions hold on the same cycle. No mask is set and no timeout pulse is issued.
  - grt_in is ignored in BUSY, and changes on it do not preempt the owner.
- GAP:
  - Exactly one cycle with gnt=0, gnt_vld=0; grt_in ignored; next=IDLE.
  - timeout is high only in this cycle and only after a MAX_HOLD termination.
- req_mask:
  - Each bit i clears (registered) in any cycle where req[i]==0.
  - Set and clear cannot coincide, because a set requires req[owner]=1.
  - A masked requester is ignored until it deasserts its request for at least one cycle.
- Minimum grant length is 1 cycle; back-to-back grants are always separated by at least one GAP cycle and one IDLE cycle.
- gnt is always zero or one-hot.

Optional Feature:
- Macro: ARB_LOCK_ONEHOT_CHK_EN.
- Defined:
  - In IDLE, a g with more than one bit set is rejected: no grant, and the block stays in IDLE.
  - Adds output onehot_err (1 bit), sticky until rst.
- Not defined:
  - No checker and no onehot_err port.
  - A multi-bit g selects the lowest set index, consistent with upstream priority.

Test Plan:
- Reset: hold rst for 2 cycles with req=5'b11111 -> gnt=0, gnt_vld=0, gnt_id=0, req_mask=0, timeout=0 throughout and on the cycle after release.
- Normal release: req=5'b00100, grt_in=5'b00100 at edge t, drop req[2] after 3 BUSY cycles -> gnt=5'b00100, gnt_id=2 for cycles t+1..t+3, then 1 GAP cycle with gnt=0 and timeout=0.
- Timeout (MAX_HOLD=16): hold req[1]=1 -> gnt=5'b00010 for exactly 16 cycles; timeout=1 and req_mask=5'b00010 in the GAP cycle; grt_in=5'b00010 is then ignored until req[1] drops, after which the mask clears the next cycle.
- Preemption attempt: owner 3 in BUSY, then req[0] rises and grt_in switches to 5'b00001 -> gnt stays 5'b01000 until req[3] drops; req 0 is granted after the GAP and IDLE cycles.
- Mid-grant reset: assert rst during BUSY with owner 4 -> gnt=0 at the next edge, no timeout pulse, req_mask=0.
- Release on the final hold cycle: req[owner] drops in the same cycle hold_cnt reaches MAX_HOLD-1 -> normal release, timeout=0, req_mask unchanged; with ARB_LOCK_ONEHOT_CHK_EN, grt_in=5'b00110 in IDLE -> no grant and onehot_err=1 sticky.
